// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants for the memory bus arbiter: owner codes, FSM encodings and
// store length codes.
package mem_bus_arbiter_pkg;

  // Current owner of the shared bus
  localparam logic [1:0] BUS_OWNER_NONE  = 2'd0;
  localparam logic [1:0] BUS_OWNER_FETCH = 2'd1;
  localparam logic [1:0] BUS_OWNER_DATA  = 2'd2;

  // Arbiter FSM encodings
  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_BUS   = 2'd1;
  localparam logic [1:0] ARB_RESP  = 2'd2;
  localparam logic [1:0] ARB_ERROR = 2'd3;

  // Store length codes shared with the load/store unit
  localparam logic [2:0] RAM_NONE = 3'd0;
  localparam logic [2:0] RAM_BYTE = 3'd1;
  localparam logic [2:0] RAM_HALF = 3'd2;
  localparam logic [2:0] RAM_WORD = 3'd4;

endpackage

// File: rtl/bus_timeout_watchdog.sv
// Counts cycles spent waiting on the bus; flags expiry once the count reaches
// TIMEOUT_CYCLES - 1. The counter saturates rather than wrapping.
module bus_timeout_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] wd_cnt_d, wd_cnt_q;

  // Next count: clear wins, otherwise count up while enabled, holding at the last value
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (clear) begin
      wd_cnt_d = '0;
    end else if (enable && (wd_cnt_q != CntLast)) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end

  assign expired = (wd_cnt_q == CntLast);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between the fetch and load/store requesters. Data has
// priority over fetch, bounded by a starvation limit; a watchdog parks the
// block in ERROR if memory never acknowledges.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned STARVE_LIMIT   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_ack,
  output logic [31:0] fetch_rdata,
  input  logic        data_req,
  input  logic [31:0] data_addr,
  input  logic        data_wr_enable,
  input  logic [2:0]  data_write_length,
  input  logic [31:0] data_wr_data,
  output logic        data_ack,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic [31:0] bus_address,
  output logic [31:0] bus_wr_data,
  output logic        bus_wr_enable,
  output logic [2:0]  bus_write_length,
  input  logic [31:0] bus_read_data,
  input  logic        bus_ack,
  output logic [1:0]  bus_owner,
  output logic        timeout_error
);

  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

  logic [1:0]         state_d, state_q;
  logic [1:0]         owner_d, owner_q;
  logic [31:0]        addr_d, addr_q;
  logic [31:0]        wdata_d, wdata_q;
  logic               wen_d, wen_q;
  logic [2:0]         wlen_d, wlen_q;
  logic [31:0]        fetch_rdata_d, fetch_rdata_q;
  logic [31:0]        data_rdata_d, data_rdata_q;
  logic [StarveW-1:0] starve_cnt_d, starve_cnt_q;

  logic grant_data, grant_fetch;
  logic wd_clear, wd_enable, wd_expired;

  // Watchdog runs only while a transaction waits for its ack
  assign wd_enable = (state_q == ARB_BUS) && !bus_ack;

  bus_timeout_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  // Arbitration, request latching and FSM next-state
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wen_d         = wen_q;
    wlen_d        = wlen_q;
    fetch_rdata_d = fetch_rdata_q;
    data_rdata_d  = data_rdata_q;
    starve_cnt_d  = starve_cnt_q;
    grant_data    = 1'b0;
    grant_fetch   = 1'b0;
    wd_clear      = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        // Data wins a tie unless fetch has already lost STARVE_LIMIT times in a row
        grant_data  = data_req && !(fetch_req && (starve_cnt_q == StarveMax));
        grant_fetch = fetch_req && !grant_data;
        if (!fetch_req) begin
          starve_cnt_d = '0;
        end
        if (grant_data) begin
          addr_d   = data_addr;
          wdata_d  = data_wr_data;
          wen_d    = data_wr_enable;
          wlen_d   = data_write_length;
          owner_d  = BUS_OWNER_DATA;
          state_d  = ARB_BUS;
          wd_clear = 1'b1;
          if (fetch_req && (starve_cnt_q != StarveMax)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
          end
        end else if (grant_fetch) begin
          addr_d       = fetch_addr;
          wdata_d      = '0;
          wen_d        = 1'b0;
          wlen_d       = RAM_NONE;
          owner_d      = BUS_OWNER_FETCH;
          state_d      = ARB_BUS;
          wd_clear     = 1'b1;
          starve_cnt_d = '0;
        end
      end
      ARB_BUS: begin
        if (bus_ack) begin
          if (owner_q == BUS_OWNER_DATA) begin
            data_rdata_d = wen_q ? 32'h0 : bus_read_data;
          end else begin
            fetch_rdata_d = bus_read_data;
          end
          state_d = ARB_RESP;
        end else if (wd_expired) begin
          state_d = ARB_ERROR;
        end
      end
      ARB_RESP: begin
        state_d = ARB_IDLE;
        owner_d = BUS_OWNER_NONE;
      end
      ARB_ERROR: begin
        state_d = ARB_ERROR;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State and latch registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ARB_IDLE;
      owner_q       <= BUS_OWNER_NONE;
      addr_q        <= '0;
      wdata_q       <= '0;
      wen_q         <= 1'b0;
      wlen_q        <= '0;
      fetch_rdata_q <= '0;
      data_rdata_q  <= '0;
      starve_cnt_q  <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wen_q         <= wen_d;
      wlen_q        <= wlen_d;
      fetch_rdata_q <= fetch_rdata_d;
      data_rdata_q  <= data_rdata_d;
      starve_cnt_q  <= starve_cnt_d;
    end
  end

  // Outputs decoded from state and latched fields
  always_comb begin
    bus_req          = (state_q == ARB_BUS);
    fetch_ack        = (state_q == ARB_RESP) && (owner_q == BUS_OWNER_FETCH);
    data_ack         = (state_q == ARB_RESP) && (owner_q == BUS_OWNER_DATA);
    timeout_error    = (state_q == ARB_ERROR);
    bus_owner        = owner_q;
    bus_address      = addr_q;
    bus_wr_data      = wdata_q;
    bus_wr_enable    = wen_q;
    bus_write_length = wlen_q;
    fetch_rdata      = fetch_rdata_q;
    data_rdata       = data_rdata_q;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: lone fetch, tie-break, starvation limit,
// store with wait states, watchdog timeout and reset during a transaction.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ack;
  logic [31:0] fetch_rdata;
  logic        data_req;
  logic [31:0] data_addr;
  logic        data_wr_enable;
  logic [2:0]  data_write_length;
  logic [31:0] data_wr_data;
  logic        data_ack;
  logic [31:0] data_rdata;
  logic        bus_req;
  logic [31:0] bus_address;
  logic [31:0] bus_wr_data;
  logic        bus_wr_enable;
  logic [2:0]  bus_write_length;
  logic [31:0] bus_read_data;
  logic        bus_ack;
  logic [1:0]  bus_owner;
  logic        timeout_error;

  int total = 0;
  int bad   = 0;

  mem_bus_arbiter #(
    .TIMEOUT_CYCLES(8),
    .STARVE_LIMIT  (4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .fetch_req        (fetch_req),
    .fetch_addr       (fetch_addr),
    .fetch_ack        (fetch_ack),
    .fetch_rdata      (fetch_rdata),
    .data_req         (data_req),
    .data_addr        (data_addr),
    .data_wr_enable   (data_wr_enable),
    .data_write_length(data_write_length),
    .data_wr_data     (data_wr_data),
    .data_ack         (data_ack),
    .data_rdata       (data_rdata),
    .bus_req          (bus_req),
    .bus_address      (bus_address),
    .bus_wr_data      (bus_wr_data),
    .bus_wr_enable    (bus_wr_enable),
    .bus_write_length (bus_write_length),
    .bus_read_data    (bus_read_data),
    .bus_ack          (bus_ack),
    .bus_owner        (bus_owner),
    .timeout_error    (timeout_error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  initial begin
    reset             = 1'b0;
    fetch_req         = 1'b0;
    fetch_addr        = '0;
    data_req          = 1'b0;
    data_addr         = '0;
    data_wr_enable    = 1'b0;
    data_write_length = '0;
    data_wr_data      = '0;
    bus_read_data     = '0;
    bus_ack           = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_owner", 32'(bus_owner), 32'd0);
    chk("rst_fetch_ack", 32'(fetch_ack), 32'd0);
    chk("rst_data_ack", 32'(data_ack), 32'd0);
    chk("rst_timeout", 32'(timeout_error), 32'd0);
    chk("rst_addr", bus_address, 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(ARB_IDLE));
    reset = 1'b1;
    tick();

    // Lone fetch, zero-wait memory
    fetch_req  = 1'b1;
    fetch_addr = 32'h0000_0010;
    tick();
    chk("f1_bus_req", 32'(bus_req), 32'd1);
    chk("f1_owner", 32'(bus_owner), 32'(BUS_OWNER_FETCH));
    chk("f1_addr", bus_address, 32'h0000_0010);
    chk("f1_wen", 32'(bus_wr_enable), 32'd0);
    chk("f1_len", 32'(bus_write_length), 32'd0);
    chk("f1_no_ack_yet", 32'(fetch_ack), 32'd0);
    bus_ack       = 1'b1;
    bus_read_data = 32'h0000_0013;
    tick();
    chk("f1_ack", 32'(fetch_ack), 32'd1);
    chk("f1_rdata", fetch_rdata, 32'h0000_0013);
    chk("f1_resp_bus_req", 32'(bus_req), 32'd0);
    chk("f1_no_data_ack", 32'(data_ack), 32'd0);
    bus_ack   = 1'b0;
    fetch_req = 1'b0;
    tick();
    chk("f1_idle", 32'(dut.state_q), 32'(ARB_IDLE));
    chk("f1_ack_drop", 32'(fetch_ack), 32'd0);
    chk("f1_owner_none", 32'(bus_owner), 32'(BUS_OWNER_NONE));

    // Simultaneous requests: data first, then fetch
    fetch_req      = 1'b1;
    fetch_addr     = 32'h0000_0010;
    data_req       = 1'b1;
    data_addr      = 32'h0000_0100;
    data_wr_enable = 1'b0;
    tick();
    chk("sim_owner_data", 32'(bus_owner), 32'(BUS_OWNER_DATA));
    chk("sim_addr_data", bus_address, 32'h0000_0100);
    chk("sim_starve1", 32'(dut.starve_cnt_q), 32'd1);
    bus_ack       = 1'b1;
    bus_read_data = 32'hCAFE_0001;
    tick();
    chk("sim_data_ack", 32'(data_ack), 32'd1);
    chk("sim_data_rdata", data_rdata, 32'hCAFE_0001);
    chk("sim_no_fetch_ack", 32'(fetch_ack), 32'd0);
    bus_ack  = 1'b0;
    data_req = 1'b0;
    tick();
    chk("sim_idle", 32'(dut.state_q), 32'(ARB_IDLE));
    tick();
    chk("sim_owner_fetch", 32'(bus_owner), 32'(BUS_OWNER_FETCH));
    chk("sim_addr_fetch", bus_address, 32'h0000_0010);
    bus_ack       = 1'b1;
    bus_read_data = 32'h0000_0093;
    tick();
    chk("sim_fetch_ack", 32'(fetch_ack), 32'd1);
    chk("sim_fetch_rdata", fetch_rdata, 32'h0000_0093);
    chk("sim_starve_clr", 32'(dut.starve_cnt_q), 32'd0);
    bus_ack   = 1'b0;
    fetch_req = 1'b0;
    tick();

    // Starvation limit: four data grants, then fetch
    fetch_req     = 1'b1;
    fetch_addr    = 32'h0000_0020;
    data_req      = 1'b1;
    data_addr     = 32'h0000_0104;
    bus_ack       = 1'b1;
    bus_read_data = 32'h0000_0011;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stv_owner_data", 32'(bus_owner), 32'(BUS_OWNER_DATA));
      chk("stv_cnt", 32'(dut.starve_cnt_q), 32'(i + 1));
      tick();
      chk("stv_data_ack", 32'(data_ack), 32'd1);
      tick();
    end
    tick();
    chk("stv_owner_fetch", 32'(bus_owner), 32'(BUS_OWNER_FETCH));
    chk("stv_addr_fetch", bus_address, 32'h0000_0020);
    chk("stv_cnt_clr", 32'(dut.starve_cnt_q), 32'd0);
    tick();
    chk("stv_fetch_ack", 32'(fetch_ack), 32'd1);
    fetch_req = 1'b0;
    data_req  = 1'b0;
    bus_ack   = 1'b0;
    tick();

    // Store with three wait cycles
    data_req          = 1'b1;
    data_addr         = 32'h0000_0200;
    data_wr_enable    = 1'b1;
    data_write_length = RAM_WORD;
    data_wr_data      = 32'hDEAD_BEEF;
    bus_read_data     = 32'h1234_5678;
    tick();
    for (int c = 1; c <= 4; c++) begin
      chk("st_bus_req", 32'(bus_req), 32'd1);
      chk("st_wen", 32'(bus_wr_enable), 32'd1);
      chk("st_addr", bus_address, 32'h0000_0200);
      chk("st_wdata", bus_wr_data, 32'hDEAD_BEEF);
      chk("st_len", 32'(bus_write_length), 32'(RAM_WORD));
      chk("st_no_ack", 32'(data_ack), 32'd0);
      if (c == 4) bus_ack = 1'b1;
      tick();
    end
    chk("st_data_ack", 32'(data_ack), 32'd1);
    chk("st_rdata_zero", data_rdata, 32'd0);
    chk("st_resp_bus_req", 32'(bus_req), 32'd0);
    data_req          = 1'b0;
    data_wr_enable    = 1'b0;
    data_write_length = '0;
    bus_ack           = 1'b0;
    tick();

    // Watchdog timeout with TIMEOUT_CYCLES = 8
    fetch_req  = 1'b1;
    fetch_addr = 32'h0000_0040;
    tick();
    chk("to_bus_req_rise", 32'(bus_req), 32'd1);
    for (int c = 2; c <= 8; c++) tick();
    chk("to_c8_bus_req", 32'(bus_req), 32'd1);
    chk("to_c8_no_err", 32'(timeout_error), 32'd0);
    tick();
    chk("to_err", 32'(timeout_error), 32'd1);
    chk("to_err_bus_req", 32'(bus_req), 32'd0);
    bus_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("to_sticky", 32'(timeout_error), 32'd1);
      chk("to_no_fetch_ack", 32'(fetch_ack), 32'd0);
      chk("to_no_data_ack", 32'(data_ack), 32'd0);
      chk("to_no_bus_req", 32'(bus_req), 32'd0);
    end
    reset     = 1'b0;
    fetch_req = 1'b0;
    bus_ack   = 1'b0;
    tick();
    chk("to_rst_clear", 32'(timeout_error), 32'd0);
    chk("to_rst_idle", 32'(dut.state_q), 32'(ARB_IDLE));
    reset = 1'b1;
    tick();

    // Reset while a store waits in BUS, then a late ack
    data_req          = 1'b1;
    data_addr         = 32'h0000_0300;
    data_wr_enable    = 1'b1;
    data_write_length = RAM_WORD;
    data_wr_data      = 32'h55AA_55AA;
    tick();
    tick();
    chk("rb_bus_req", 32'(bus_req), 32'd1);
    chk("rb_wdata", bus_wr_data, 32'h55AA_55AA);
    reset = 1'b0;
    tick();
    chk("rb_state", 32'(dut.state_q), 32'(ARB_IDLE));
    chk("rb_bus_req0", 32'(bus_req), 32'd0);
    chk("rb_addr0", bus_address, 32'd0);
    chk("rb_wdata0", bus_wr_data, 32'd0);
    chk("rb_wen0", 32'(bus_wr_enable), 32'd0);
    chk("rb_len0", 32'(bus_write_length), 32'd0);
    chk("rb_owner0", 32'(bus_owner), 32'd0);
    chk("rb_data_ack0", 32'(data_ack), 32'd0);
    reset          = 1'b1;
    data_req       = 1'b0;
    data_wr_enable = 1'b0;
    bus_ack        = 1'b1;
    bus_read_data  = 32'hFFFF_FFFF;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rb_late_no_data_ack", 32'(data_ack), 32'd0);
      chk("rb_late_no_fetch_ack", 32'(fetch_ack), 32'd0);
      chk("rb_late_bus_req", 32'(bus_req), 32'd0);
      chk("rb_late_rdata", data_rdata, 32'd0);
      chk("rb_late_state", 32'(dut.state_q), 32'(ARB_IDLE));
    end
    bus_ack = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
